axi_w_last_gen: RTL
===================

AXI_W_LAST_GEN -- requirements
Module: axi_w_last_gen

Interface
REQ-001 The module SHALL have parameter ID_WIDTH, default 4, meaning the width of the AXI ID.
REQ-002 The module SHALL have parameter LEN_WIDTH, default 8, meaning the width of the AXI burst length (beats minus 1).
REQ-003 The module SHALL have parameter DATA_WIDTH, default 32, meaning the width of W data; the strobe width is DATA_WIDTH/8.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The module SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port flush_i, input, 1 bit: synchronous abort of the active burst and the output stage.
REQ-007 The module SHALL have port cmd_empty_i, input, 1 bit: command FIFO empty flag.
REQ-008 The module SHALL have port cmd_data_i, input, ID_WIDTH+LEN_WIDTH bits: command FIFO head, laid out as {id, len} with len in the LSBs.
REQ-009 The module SHALL have port cmd_pop_o, output, 1 bit: command FIFO pop strobe.
REQ-010 The module SHALL have ports w_data_i (DATA_WIDTH), w_strb_i (DATA_WIDTH/8), w_valid_i (1) as inputs and w_ready_o (1) as an output: the upstream W beat channel.
REQ-011 The module SHALL have ports w_data_o (DATA_WIDTH), w_strb_o (DATA_WIDTH/8), w_id_o (ID_WIDTH), w_last_o (1), w_valid_o (1) as outputs and w_ready_i (1) as an input: the downstream W channel.

Function
REQ-012 The FSM SHALL have two states: IDLE (no burst loaded) and BURST (burst loaded, beat counter active).
REQ-013 In IDLE with cmd_empty_i=0, cmd_pop_o SHALL be 1 for exactly that cycle; {id, len} SHALL be latched, the beat counter cleared to 0, and the next state SHALL be BURST.
REQ-014 cmd_pop_o SHALL be 0 whenever cmd_empty_i=1, flush_i=1 or rst_ni=0.
REQ-015 w_ready_o SHALL equal (state==BURST) & (~w_valid_o | w_ready_i), so the module never accepts a beat in IDLE.
REQ-016 An upstream beat is accepted when w_valid_i & w_ready_o; on acceptance the output register SHALL load data, strb, latched id, and w_last_o = (counter==len), and w_valid_o SHALL be set on the next cycle (latency 1).
REQ-017 When w_ready_i=1 and no new beat is accepted, w_valid_o SHALL clear on the next cycle; while w_valid_o=1 and w_ready_i=0, the output register SHALL hold stable.
REQ-018 On each accepted non-last beat, the counter SHALL increment by 1; the counter is LEN_WIDTH bits wide and SHALL never wrap, because the last beat ends the burst.
REQ-019 On acceptance of the last beat (counter==len): if cmd_empty_i=0, cmd_pop_o SHALL be 1 in the same cycle, the next command SHALL be loaded, and the state SHALL stay BURST with no bubble; otherwise the next state SHALL be IDLE.
REQ-020 len=0 SHALL produce a single beat with w_last_o=1; len=2^LEN_WIDTH-1 SHALL produce 2^LEN_WIDTH beats.
REQ-021 flush_i=1 SHALL clear w_valid_o and w_last_o, force IDLE, and reset the counter on the next edge; no pop or accept SHALL occur in that cycle, and flush_i SHALL take priority over all other events.

Reset
REQ-022 While rst_ni=0, the state SHALL be IDLE, the counter, latched id and latched len SHALL be 0, and w_valid_o, w_last_o, w_data_o, w_strb_o and w_id_o SHALL all be 0.
REQ-023 Reset asserted mid-burst SHALL discard the burst; after release, the module SHALL resume from IDLE on the next FIFO entry.

Configuration
REQ-024 With macro AXI_W_LAST_CHECK_EN defined, the module SHALL have input w_last_i and output err_o; err_o SHALL be set (sticky until reset) on the cycle after any accepted beat where w_last_i differs from the generated last.
REQ-025 Without AXI_W_LAST_CHECK_EN, the w_last_i and err_o ports SHALL be absent and no check logic SHALL be built.

Verification
REQ-026 FIFO holds {id=3,len=3}; w_valid_i=1 and w_ready_i=1 held -> 4 beats out with id 3, w_last_o=1 on beat 4 only, and one cmd_pop_o pulse.
REQ-027 Two queued commands {1,0} and {2,1}, continuous traffic -> 3 back-to-back output beats with last pattern 1,0,1 and no idle cycle between the bursts.
REQ-028 w_ready_i=0 for 5 cycles mid-burst -> output stable, w_ready_o=0, and no beat lost or duplicated.
REQ-029 flush_i pulsed after beat 2 of len=7 -> w_valid_o=0 next cycle, IDLE state, and the next command starts at counter 0.
REQ-030 rst_ni asserted mid-burst -> all outputs 0 immediately (asynchronously); with AXI_W_LAST_CHECK_EN, w_last_i=1 on beat 1 of len=1 -> err_o=1 the following cycle and held.

Source files
------------

// File: rtl/axi_w_last_gen.sv
// Generates WLAST and WID for an AXI write-data stream from {id, len} burst commands.
// Optional AXI_W_LAST_CHECK_EN adds w_last_i and a sticky err_o comparing upstream WLAST.
module axi_w_last_gen #(
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          cmd_empty_i,
    input  logic [ID_WIDTH+LEN_WIDTH-1:0] cmd_data_i,
    output logic                          cmd_pop_o,
    input  logic [DATA_WIDTH-1:0]         w_data_i,
    input  logic [DATA_WIDTH/8-1:0]       w_strb_i,
    input  logic                          w_valid_i,
    output logic                          w_ready_o,
    output logic [DATA_WIDTH-1:0]         w_data_o,
    output logic [DATA_WIDTH/8-1:0]       w_strb_o,
    output logic [ID_WIDTH-1:0]           w_id_o,
    output logic                          w_last_o,
    output logic                          w_valid_o,
`ifdef AXI_W_LAST_CHECK_EN
    input  logic                          w_last_i,
    output logic                          err_o,
`endif
    input  logic                          w_ready_i
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e                  state_q;
    logic [LEN_WIDTH-1:0]    cnt_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [ID_WIDTH-1:0]     id_q;

    logic                    vld_p1;
    logic                    last_p1;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic [DATA_WIDTH/8-1:0] strb_p1;
    logic [ID_WIDTH-1:0]     id_p1;

    logic                    accept_p0;
    logic                    is_last_p0;
    logic [LEN_WIDTH-1:0]    cmd_len;
    logic [ID_WIDTH-1:0]     cmd_id;

    assign cmd_len = cmd_data_i[LEN_WIDTH-1:0];
    assign cmd_id  = cmd_data_i[ID_WIDTH+LEN_WIDTH-1:LEN_WIDTH];

    // Flush also blocks the handshake so upstream never sees a beat as taken while it is dropped.
    assign w_ready_o  = ~flush_i & (state_q == BURST) & (~vld_p1 | w_ready_i);
    assign accept_p0  = w_valid_i & w_ready_o;
    assign is_last_p0 = (cnt_q == len_q);

    // Pop in IDLE, or on the last beat so the next burst follows without a bubble.
    assign cmd_pop_o = rst_ni & ~flush_i & ~cmd_empty_i &
                       ((state_q == IDLE) | (accept_p0 & is_last_p0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            data_p1 <= '0;
            strb_p1 <= '0;
            id_p1   <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            // p0 -> p1: accepted beat enters the output register
            if (accept_p0) begin
                data_p1 <= w_data_i;
                strb_p1 <= w_strb_i;
                id_p1   <= id_q;
                last_p1 <= is_last_p0;
                vld_p1  <= 1'b1;
            end else if (w_ready_i) begin
                vld_p1  <= 1'b0;
            end

            if (cmd_pop_o) begin
                id_q    <= cmd_id;
                len_q   <= cmd_len;
                cnt_q   <= '0;
                state_q <= BURST;
            end else if (accept_p0) begin
                if (is_last_p0) begin
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + LEN_WIDTH'(1);
                end
            end
        end
    end

    assign w_valid_o = vld_p1;
    assign w_last_o  = last_p1;
    assign w_data_o  = data_p1;
    assign w_strb_o  = strb_p1;
    assign w_id_o    = id_p1;

`ifdef AXI_W_LAST_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (accept_p0 && (w_last_i != is_last_p0)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

endmodule
